// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP,
    DONE
  } state_t;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // The shifted remainder keeps rem's old MSB as bit WIDTH, so divisors with
  // the top bit set still compare correctly.
  logic [WIDTH:0] rem_shifted;
  logic [WIDTH:0] trial;

  assign rem_shifted = {rem, quo[WIDTH-1]};
  assign trial       = rem_shifted - {1'b0, dsr};

  assign rem_next = trial[WIDTH] ? rem_shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider with valid/ready operand and result handshakes.
// Optional signed (truncating) division is enabled by defining DIV_SIGNED_EN.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quo, dsr;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] ld_quo, ld_dsr;
  logic             dbz;

`ifdef DIV_SIGNED_EN
  logic a_neg, b_neg, neg_q, neg_r;

  assign a_neg  = is_signed & dividend[WIDTH-1];
  assign b_neg  = is_signed & divisor[WIDTH-1];
  assign ld_quo = a_neg ? -dividend : dividend;
  assign ld_dsr = b_neg ? -divisor : divisor;
`else
  assign ld_quo = dividend;
  assign ld_dsr = divisor;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .dsr      (dsr),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:  if (in_valid) state_next = (divisor == '0) ? DONE : RUN;
`ifdef DIV_SIGNED_EN
      RUN:   if (count == CW'(1)) state_next = FIXUP;
      FIXUP: state_next = DONE;
`else
      RUN:   if (count == CW'(1)) state_next = DONE;
`endif
      DONE:  if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      dsr         <= '0;
      dbz         <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          count <= CW'(WIDTH);
          dsr   <= ld_dsr;
          if (divisor == '0) begin
            rem <= dividend;
            quo <= '1;
            dbz <= 1'b1;
          end else begin
            rem <= '0;
            quo <= ld_quo;
            dbz <= 1'b0;
          end
`ifdef DIV_SIGNED_EN
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
`endif
        end
        RUN: begin
          rem   <= step_rem;
          quo   <= step_quo;
          count <= count - CW'(1);
        end
`ifdef DIV_SIGNED_EN
        FIXUP: begin
          if (neg_q) quo <= -quo;
          if (neg_r) rem <= -rem;
        end
`endif
        DONE: begin
          // Result registers are captured once; out_valid rises the cycle after entry.
          if (!out_valid) begin
            out_valid   <= 1'b1;
            quotient    <= quo;
            remainder   <= rem;
            div_by_zero <= dbz;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed cases, backpressure, mid-run reset, random sweep.
module tb_seq_divider;

  localparam int W = 32;
`ifdef DIV_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [W-1:0] dividend, divisor, quotient, remainder;
`ifdef DIV_SIGNED_EN
  logic         is_signed;
`endif

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         dbz;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_SIGNED_EN
    .is_signed   (is_signed),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    exp_t e;
    e.a = a; e.b = b; e.lat = LAT; e.dbz = 1'b0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 1;
    end else if (!sgn) begin
      e.q = a / b; e.r = a % b;
    end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
      e.q = a; e.r = '0;
    end else begin
      e.q = W'($signed(a) / $signed(b));
      e.r = W'($signed(a) % $signed(b));
    end
    return e;
  endfunction

  // Drive one operand pair from a negedge while in_ready is high; returns after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", {63'b0, in_ready}, 64'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
`ifdef DIV_SIGNED_EN
    is_signed = sgn;
`endif
    sb.push_back(model(a, b, sgn));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Wait (bounded) for out_valid counting edges after the accept edge, compare, optionally release.
  task automatic collect(input string tag, input bit inv, input bit release_out);
    int           lat  = 0;
    bit           done = 0;
    exp_t         e;
    logic [63:0]  recon;
    while (!done && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) done = 1;
    end
    e = sb.pop_front();
    if (!done) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    check({tag, "_lat"}, 64'(lat), 64'(e.lat));
    check({tag, "_q"}, 64'(quotient), 64'(e.q));
    check({tag, "_r"}, 64'(remainder), 64'(e.r));
    check({tag, "_dbz"}, {63'b0, div_by_zero}, {63'b0, e.dbz});
    if (inv) begin
      recon = 64'(quotient) * 64'(e.b) + 64'(remainder);
      check({tag, "_inv"}, recon, 64'(e.a));
      check({tag, "_rem_lt"}, {63'b0, remainder < e.b}, 64'd1);
    end
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0] a, b, held_q, held_r;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
`ifdef DIV_SIGNED_EN
    is_signed = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_q", 64'(quotient), 64'd0);
    check("rst_r", 64'(remainder), 64'd0);
    check("rst_dbz", {63'b0, div_by_zero}, 64'd0);
    reset = 1'b0;

    send(32'd100, 32'd7, 1'b0);           collect("d100_7", 1, 1);
    send(32'hFFFF_FFFF, 32'd1, 1'b0);     collect("dmax_1", 1, 1);
    send(32'd5, 32'd9, 1'b0);             collect("d5_9", 1, 1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); collect("dmax_max", 1, 1);
    send(32'hFFFF_FFFE, 32'h8000_0001, 1'b0); collect("dbig_div", 1, 1);
    send(32'h1234_5678, 32'd0, 1'b0);     collect("dzero", 0, 1);

    // Backpressure: result held, new operands offered but refused.
    send(32'd1000, 32'd3, 1'b0);
    collect("bp", 1, 0);
    held_q = quotient; held_r = remainder;
    in_valid = 1'b1; dividend = 32'd77; divisor = 32'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_in_ready", {63'b0, in_ready}, 64'd0);
      check("bp_out_valid", {63'b0, out_valid}, 64'd1);
      check("bp_q_hold", 64'(quotient), 64'(held_q));
      check("bp_r_hold", 64'(remainder), 64'(held_r));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_ready_after", {63'b0, in_ready}, 64'd1);
    check("bp_valid_after", {63'b0, out_valid}, 64'd0);
    sb.push_back(model(32'd77, 32'd5, 1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    collect("bp_next", 1, 1);

    // Reset in the middle of a divide.
    send(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mrst_in_ready", {63'b0, in_ready}, 64'd1);
    check("mrst_out_valid", {63'b0, out_valid}, 64'd0);
    check("mrst_q", 64'(quotient), 64'd0);
    check("mrst_r", 64'(remainder), 64'd0);
    check("mrst_dbz", {63'b0, div_by_zero}, 64'd0);
    reset = 1'b0;
    sb.delete();
    send(32'd100, 32'd7, 1'b0);           collect("mrst_redo", 1, 1);

`ifdef DIV_SIGNED_EN
    send(-32'sd7, 32'd2, 1'b1);           collect("s_m7_2", 0, 1);
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); collect("s_ovf", 0, 1);
    send(32'd7, -32'sd2, 1'b1);           collect("s_7_m2", 0, 1);
    send(-32'sd9, 32'd0, 1'b1);           collect("s_dzero", 0, 1);
`endif

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == '0) b = 32'd1;
      send(a, b, 1'b0);
      collect("rand", 1, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
